// File: rtl/weight_bias_streamer_pkg.sv
// Shared types and constants for the weight/bias streamer.
// Latency: n/a (declarations only).
// Backpressure: n/a (declarations only).
package weight_bias_streamer_pkg;

   // Datapath word width of the RAMs and of the PE weight/bias ports.
   localparam int WORD_BITS = 16;

   // Controller opcode for a MAC layer.
   localparam logic [3:0] EXE_MAC = 4'd2;

   // Streamer sequencing states.
   typedef enum logic [1:0] {
      WBS_IDLE  = 2'd0,
      WBS_RUN   = 2'd1,
      WBS_DRAIN = 2'd2,
      WBS_DONE  = 2'd3
   } wbs_state_t;

   // One captured RAM read: 'first' marks the first weight of an output channel,
   // the only beat whose bias is meaningful.
   typedef struct packed {
      logic                 first;
      logic [WORD_BITS-1:0] weight;
      logic [WORD_BITS-1:0] bias;
   } wb_entry_t;

endpackage

// File: rtl/wb_skid_fifo.sv
// Two-entry register FIFO that absorbs in-flight RAM reads while the PE array stalls.
// Latency: a push is visible at the head on the next cycle; head/count come straight from registers.
// Backpressure: a push into a full FIFO is only accepted together with a pop; the issuer never overfills it.
module wb_skid_fifo
   import weight_bias_streamer_pkg::*;
(
   input  logic       CLK,
   input  logic       RST,
   input  logic       push,
   input  wb_entry_t  push_dat,
   input  logic       pop,
   output logic [1:0] count,
   output wb_entry_t  head
);

   wb_entry_t mem0;
   wb_entry_t mem1;
   logic      do_pop;
   logic      do_push;

   assign do_pop  = pop & (count != 2'd0);
   assign do_push = push & ((count != 2'd2) | do_pop);
   assign head    = mem0;

   // Entry 0 is always the head; a pop shifts entry 1 forward.
   always_ff @(posedge CLK) begin
      if (!RST) begin
         count <= 2'd0;
         mem0  <= '0;
         mem1  <= '0;
      end else begin
         case ({do_push, do_pop})
            2'b10: begin
               if (count == 2'd0) mem0 <= push_dat;
               else               mem1 <= push_dat;
               count <= count + 2'd1;
            end
            2'b01: begin
               mem0  <= mem1;
               count <= count - 2'd1;
            end
            2'b11: begin
               if (count == 2'd1) begin
                  mem0 <= push_dat;
               end else begin
                  mem0 <= mem1;
                  mem1 <= push_dat;
               end
            end
            default: ;
         endcase
      end
   end

endmodule

// File: rtl/weight_bias_streamer.sv
// Reads Weight/Bias RAMs for a MAC layer and streams weights, plus one bias per output channel, to the PEs.
// Latency: start at cycle 0, first RAM read at cycle 1, first beat at cycle 3; one beat per cycle after that.
// Backpressure: En_in low holds the head beat and stops new reads; pending reads land in a 2-entry FIFO.
module weight_bias_streamer
   import weight_bias_streamer_pkg::*;
#(
   parameter int WADDR_BITS = 10,
   parameter int BADDR_BITS = 6,
   parameter int CNT_BITS   = 10
)(
   input  logic                        CLK,
   input  logic                        RST,
   input  logic                        start_in,
   input  logic                        layer_done_in,
   input  logic                        En_in,
   input  logic [CNT_BITS-1:0]         kernel_len_in,
   input  logic [BADDR_BITS-1:0]       num_oc_in,
   input  logic [WADDR_BITS-1:0]       w_base_in,
   input  logic [BADDR_BITS-1:0]       b_base_in,
   output logic                        WRAM_en_out,
   output logic [WADDR_BITS-1:0]       WRAM_addr_out,
   input  logic [WORD_BITS-1:0]        WRAM_data_in,
   output logic                        BRAM_en_out,
   output logic [BADDR_BITS-1:0]       BRAM_addr_out,
   input  logic [WORD_BITS-1:0]        BRAM_data_in,
   output logic                        Weight_valid_out,
   output logic signed [WORD_BITS-1:0] Weight_out,
   output logic                        Bias_valid_out,
   output logic signed [WORD_BITS-1:0] Bias_out,
   output logic                        busy_out,
   output logic                        done_out
);

   wbs_state_t            state;
   logic [CNT_BITS-1:0]   k_len;
   logic [CNT_BITS-1:0]   k_cnt;
   logic [BADDR_BITS-1:0] n_oc;
   logic [BADDR_BITS-1:0] oc_cnt;
   logic [BADDR_BITS-1:0] b_base;
   logic [WADDR_BITS-1:0] w_addr;
   logic                  pend;
   logic                  pend_first;
   logic [1:0]            fifo_cnt;
   wb_entry_t             fifo_head;
   wb_entry_t             fifo_in;
   logic                  fifo_rst;
   logic                  pop;
   logic                  issue;
   logic                  k_last;
   logic                  oc_last;
   logic [2:0]            occ;

   // A read may be issued only if the FIFO can still hold it once every read in flight has landed.
   assign pop     = (fifo_cnt != 2'd0) & En_in;
   assign occ     = {1'b0, fifo_cnt} + {2'b00, pend} - {2'b00, pop};
   assign issue   = (state == WBS_RUN) & En_in & (occ < 3'd2);
   assign k_last  = (k_cnt == k_len - CNT_BITS'(1));
   assign oc_last = (oc_cnt == n_oc - BADDR_BITS'(1));

   assign WRAM_en_out   = issue;
   assign WRAM_addr_out = w_addr;
   assign BRAM_en_out   = issue & (k_cnt == '0);
   assign BRAM_addr_out = b_base + oc_cnt;

   // Abort flushes the FIFO exactly like a reset does.
   assign fifo_rst = RST & ~layer_done_in;
   assign fifo_in  = '{first: pend_first, weight: WRAM_data_in, bias: BRAM_data_in};

   wb_skid_fifo u_fifo (
      .CLK      (CLK),
      .RST      (fifo_rst),
      .push     (pend),
      .push_dat (fifo_in),
      .pop      (pop),
      .count    (fifo_cnt),
      .head     (fifo_head)
   );

   assign Weight_valid_out = (fifo_cnt != 2'd0);
   assign Weight_out       = fifo_head.weight;
   assign Bias_valid_out   = Weight_valid_out & fifo_head.first;
   assign Bias_out         = Bias_valid_out ? fifo_head.bias : '0;

   // Sequencer: state, read counters, in-flight read tracking and registered status outputs.
   always_ff @(posedge CLK) begin
      if (!RST || layer_done_in) begin
         state      <= WBS_IDLE;
         busy_out   <= 1'b0;
         done_out   <= 1'b0;
         pend       <= 1'b0;
         pend_first <= 1'b0;
         k_len      <= '0;
         k_cnt      <= '0;
         n_oc       <= '0;
         oc_cnt     <= '0;
         b_base     <= '0;
         w_addr     <= '0;
      end else begin
         pend       <= issue;
         pend_first <= issue & (k_cnt == '0);
         if (issue) begin
            w_addr <= w_addr + WADDR_BITS'(1);
            if (k_last) begin
               k_cnt  <= '0;
               oc_cnt <= oc_cnt + BADDR_BITS'(1);
            end else begin
               k_cnt <= k_cnt + CNT_BITS'(1);
            end
         end
         case (state)
            WBS_IDLE: begin
               if (start_in) begin
                  k_len    <= kernel_len_in;
                  n_oc     <= num_oc_in;
                  w_addr   <= w_base_in;
                  b_base   <= b_base_in;
                  k_cnt    <= '0;
                  oc_cnt   <= '0;
                  busy_out <= 1'b1;
                  if ((kernel_len_in != '0) && (num_oc_in != '0)) begin
                     state <= WBS_RUN;
                  end else begin
                     state    <= WBS_DONE;
                     done_out <= 1'b1;
                  end
               end
            end
            WBS_RUN: begin
               if (issue && k_last && oc_last) state <= WBS_DRAIN;
            end
            WBS_DRAIN: begin
               if ((fifo_cnt == 2'd0) && !pend) begin
                  state    <= WBS_DONE;
                  done_out <= 1'b1;
               end
            end
            WBS_DONE: begin
               state    <= WBS_IDLE;
               busy_out <= 1'b0;
               done_out <= 1'b0;
            end
            default: state <= WBS_IDLE;
         endcase
      end
   end

endmodule
